mod_counter: RTL and testbench

Parametrised modulo up/down counter. Successor to the fixed 12-bit free-running counter.
- Adds programmable terminal value, direction control, enable, synchronous load/clear, wrap or saturate mode, terminal-count pulse and sticky overflow flag.
- Used as the general-purpose timebase/event counter in lab datapaths (decade counters, display scan dividers, event tallies).

---
 rtl/mod_counter.sv | 126 ++++++++++++
 tb/tb_mod_counter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// Modulo up/down counter with wrap/saturate modes, terminal-count pulse and sticky overflow.
// Optional enabled-cycle prescaler is built only when MOD_COUNTER_PRESCALE_EN is defined.
module mod_counter #(
  parameter int unsigned WIDTH    = 32'd12,
  parameter int unsigned MAX_VAL  = 32'd4095,
  parameter int unsigned PRESCALE = 32'd1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(32'd1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step_s;

`ifdef MOD_COUNTER_PRESCALE_EN
  localparam int unsigned   PW      = (PRESCALE > 32'd1) ? $clog2(PRESCALE) : 32'd1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 32'd1);

  logic [PW-1:0] presc_q, presc_d;

  assign step_s = en && (presc_q == PS_LAST);

  // Prescaler phase: frozen while disabled, restarted by clear or load
  always_comb begin
    presc_d = presc_q;
    if (clear || load) begin
      presc_d = '0;
    end else if (!en) begin
      presc_d = presc_q;
    end else if (presc_q == PS_LAST) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(32'd1);
    end
  end

  // Prescaler phase register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  // PRESCALE has no effect in this build
  logic unused_prescale_s;
  assign unused_prescale_s = (PRESCALE != 32'd0);
  assign step_s            = en;
`endif

  // Next count, terminal pulse and overflow: clear > load > step > hold
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = (load_val > MAX_C) ? MAX_C : load_val;
    end else if (step_s) begin
      if (up) begin
        if (count_q < MAX_C) begin
          count_d = count_q + ONE_C;
          tc_d    = sat && (count_q == MAX_C - ONE_C);
        end else begin
          ovf_d = 1'b1;
          if (sat) begin
            count_d = count_q;
          end else begin
            count_d = '0;
            tc_d    = 1'b1;
          end
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - ONE_C;
          tc_d    = sat && (count_q == ONE_C);
        end else begin
          ovf_d = 1'b1;
          if (sat) begin
            count_d = count_q;
          end else begin
            count_d = MAX_C;
            tc_d    = 1'b1;
          end
        end
      end
    end else begin
      count_d = count_q;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: four instances (4095, 9, 0, 9 with PRESCALE=4) share stimulus and
// are compared every cycle against an integer model, plus directed literal expectations.
module tb_mod_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0, up = 1'b1, sat = 1'b0, clear = 1'b0, load = 1'b0;
  logic [11:0] load_val = 12'd0;

  logic [11:0] count_a;
  logic [3:0]  count_b, count_c, count_d;
  logic        tc_a, tc_b, tc_c, tc_d;
  logic        ovf_a, ovf_b, ovf_c, ovf_d;

  int checks = 0;
  int errors = 0;

  int mc[4], mtc[4], movf[4], mpre[4];
  int mmax[4] = '{4095, 9, 0, 9};
`ifdef MOD_COUNTER_PRESCALE_EN
  int mps[4]    = '{1, 1, 1, 4};
  int exp_d8[8] = '{0, 0, 0, 1, 1, 1, 1, 2};
  int exp_dh    = 2;
  int exp_d2[2] = '{2, 3};
`else
  int mps[4]    = '{1, 1, 1, 1};
  int exp_d8[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
  int exp_dh    = 0;
  int exp_d2[2] = '{1, 2};
`endif

  mod_counter u_a (.clk(clk), .reset(reset), .en(en), .up(up), .sat(sat), .clear(clear),
                   .load(load), .load_val(load_val), .count(count_a), .tc(tc_a), .ovf(ovf_a));
  mod_counter #(.WIDTH(32'd4), .MAX_VAL(32'd9)) u_b (.clk(clk), .reset(reset), .en(en),
                   .up(up), .sat(sat), .clear(clear), .load(load), .load_val(load_val[3:0]),
                   .count(count_b), .tc(tc_b), .ovf(ovf_b));
  mod_counter #(.WIDTH(32'd4), .MAX_VAL(32'd0)) u_c (.clk(clk), .reset(reset), .en(en),
                   .up(up), .sat(sat), .clear(clear), .load(load), .load_val(load_val[3:0]),
                   .count(count_c), .tc(tc_c), .ovf(ovf_c));
  mod_counter #(.WIDTH(32'd4), .MAX_VAL(32'd9), .PRESCALE(32'd4)) u_d (.clk(clk),
                   .reset(reset), .en(en), .up(up), .sat(sat), .clear(clear), .load(load),
                   .load_val(load_val[3:0]), .count(count_d), .tc(tc_d), .ovf(ovf_d));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model of one counter for one clock edge, written from the counting rules
  task automatic model_edge(input int k);
    int lv;
    lv = (k == 0) ? int'(load_val) : int'(load_val[3:0]);
    if (clear) begin
      mc[k] = 0; movf[k] = 0; mtc[k] = 0; mpre[k] = 0;
    end else if (load) begin
      mc[k] = (lv > mmax[k]) ? mmax[k] : lv; mtc[k] = 0; mpre[k] = 0;
    end else if (!en) begin
      mtc[k] = 0;
    end else if (mpre[k] < mps[k] - 1) begin
      mpre[k] = mpre[k] + 1; mtc[k] = 0;
    end else begin
      mpre[k] = 0; mtc[k] = 0;
      if (up) begin
        if (mc[k] == mmax[k]) begin
          movf[k] = 1;
          if (!sat) begin mc[k] = 0; mtc[k] = 1; end
        end else begin
          mc[k] = mc[k] + 1;
          if (sat && mc[k] == mmax[k]) mtc[k] = 1;
        end
      end else begin
        if (mc[k] == 0) begin
          movf[k] = 1;
          if (!sat) begin mc[k] = mmax[k]; mtc[k] = 1; end
        end else begin
          mc[k] = mc[k] - 1;
          if (sat && mc[k] == 0) mtc[k] = 1;
        end
      end
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) begin mc[k] = 0; mtc[k] = 0; movf[k] = 0; mpre[k] = 0; end
    end else begin
      for (int k = 0; k < 4; k++) model_edge(k);
    end
  end

  always @(negedge clk) begin
    chk("a.count", int'(count_a), mc[0]); chk("a.tc", int'(tc_a), mtc[0]); chk("a.ovf", int'(ovf_a), movf[0]);
    chk("b.count", int'(count_b), mc[1]); chk("b.tc", int'(tc_b), mtc[1]); chk("b.ovf", int'(ovf_b), movf[1]);
    chk("c.count", int'(count_c), mc[2]); chk("c.tc", int'(tc_c), mtc[2]); chk("c.ovf", int'(ovf_c), movf[2]);
    chk("d.count", int'(count_d), mc[3]); chk("d.tc", int'(tc_d), mtc[3]); chk("d.ovf", int'(ovf_d), movf[3]);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    chk("rst.count", int'(count_a), 0); chk("rst.tc", int'(tc_a), 0); chk("rst.ovf", int'(ovf_a), 0);
    #10 reset = 1'b1;
    en = 1'b1; up = 1'b1; sat = 1'b0;

    // Free-running wrap count on the default instance; MAX_VAL=0 pulses every step
    tick;
    chk("a.first", int'(count_a), 1); chk("c.tc1", int'(tc_c), 1); chk("c.count1", int'(count_c), 0);
    tick;
    chk("c.tc2", int'(tc_c), 1);
    repeat (4093) tick;
    chk("a.4095", int'(count_a), 4095); chk("a.tc4095", int'(tc_a), 0); chk("a.ovf4095", int'(ovf_a), 0);
    tick;
    chk("a.wrap", int'(count_a), 0); chk("a.tcwrap", int'(tc_a), 1); chk("a.ovfwrap", int'(ovf_a), 1);
    tick;
    chk("a.tcdrop", int'(tc_a), 0); chk("a.after1", int'(count_a), 1);
    repeat (2) tick;
    chk("a.after3", int'(count_a), 3);

    // Asynchronous reset between edges
    load_val = 12'd1234; load = 1'b1;
    tick;
    load = 1'b0;
    chk("a.load1234", int'(count_a), 1234); chk("a.ovfkept", int'(ovf_a), 1);
    #2 reset = 1'b0;
    #1;
    chk("arst.count", int'(count_a), 0); chk("arst.tc", int'(tc_a), 0); chk("arst.ovf", int'(ovf_a), 0);
    @(negedge clk);
    #1 reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick;
      chk("arst.resume", int'(count_a), i);
    end

    // Down count wrap on MAX_VAL=9, then clamped load beats step
    clear = 1'b1; tick; clear = 1'b0; up = 1'b0;
    tick;
    chk("b.down9", int'(count_b), 9); chk("b.downtc", int'(tc_b), 1);
    tick;
    chk("b.down8", int'(count_b), 8); chk("b.downtc8", int'(tc_b), 0);
    repeat (8) tick;
    chk("b.down0", int'(count_b), 0);
    tick;
    chk("b.rewrap", int'(count_b), 9); chk("b.rewraptc", int'(tc_b), 1);
    load_val = 12'd12; load = 1'b1;
    tick;
    load = 1'b0;
    chk("b.clamp", int'(count_b), 9); chk("a.load12", int'(count_a), 12);

    // Saturate up from 7
    clear = 1'b1; tick; clear = 1'b0;
    load_val = 12'd7; load = 1'b1; tick; load = 1'b0;
    sat = 1'b1; up = 1'b1;
    tick; chk("sat.8", int'(count_b), 8); chk("sat.tc8", int'(tc_b), 0);
    tick; chk("sat.9", int'(count_b), 9); chk("sat.tc9", int'(tc_b), 1); chk("sat.ovf9", int'(ovf_b), 0);
    tick; chk("sat.hold", int'(count_b), 9); chk("sat.tchold", int'(tc_b), 0); chk("sat.ovf", int'(ovf_b), 1);
    tick; chk("sat.hold2", int'(count_b), 9);
    clear = 1'b1; tick; clear = 1'b0;
    chk("sat.clr", int'(count_b), 0); chk("sat.clrovf", int'(ovf_b), 0);

    // Clear beats load; enable low freezes
    clear = 1'b1; load = 1'b1; load_val = 12'd5; tick; clear = 1'b0;
    chk("clrload.a", int'(count_a), 0); chk("clrload.b", int'(count_b), 0);
    load_val = 12'd8; tick; load = 1'b0; sat = 1'b0;
    tick; chk("hold.pre9", int'(count_b), 9);
    tick; chk("hold.pre0", int'(count_b), 0); chk("hold.tc", int'(tc_b), 1);
    tick; chk("hold.pre1", int'(count_b), 1);
    en = 1'b0;
    repeat (5) begin
      tick;
      chk("hold.count", int'(count_b), 1); chk("hold.tc0", int'(tc_b), 0);
    end

    // Prescaler cadence and freeze mid-phase
    clear = 1'b1; tick; clear = 1'b0; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("ps.count", int'(count_d), exp_d8[i]);
    end
    repeat (2) tick;
    en = 1'b0;
    repeat (2) begin
      tick;
      chk("ps.frozen", int'(count_d), exp_dh);
    end
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("ps.resume", int'(count_d), exp_d2[i]);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
